mips_prog_loader: RTL and testbench
===================================

# mips_prog_loader

Byte-stream program loader that fills the MIPS unified word-addressed memory before the pipeline runs. It accepts framed bytes over a valid/ready handshake, packs them MSB-first into 32-bit words, and issues single-cycle memory write strobes. It holds the CPU in halt until a frame completes cleanly. It is the write side of the memory that the fetch and load stages read.

## Interface
- `ADDR_W`, default 10: memory word-address width (1024 words).
- `DATA_W`, default 32: memory word width. Fixed at 32; the packer assumes 4 bytes per word.
- `clk1`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_ready`  out  1  the loader accepts a byte this cycle.
- `in_data`  in  8  stream byte.
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address, valid while `mem_we` is high.
- `mem_wdata`  out  32  word data, valid while `mem_we` is high.
- `cpu_hold`  out  1  keeps the pipeline halted while high.
- `done`  out  1  the last frame loaded cleanly.
- `error`  out  1  frame error; sticky until `rst`.
- `words_loaded`  out  16  number of words written by the current frame.

## Operation
- Handshake: a byte is taken on a rising edge where `in_valid && in_ready`. `in_ready = (state != ERR)`, decoded from the state register only.
- Frame format: `0xA5` sync byte, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 data bytes (MSB first per word), then a CSUM byte when checksum is compiled in.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
- IDLE / DONE:
  - A byte equal to `0xA5` moves to ADDR_HI and sets `cpu_hold=1`, `done=0`, `words_loaded=0`, `csum=0`.
  - Any other byte is discarded.
- ADDR_LO:
  - If the 16-bit address has any bit set at or above ADDR_W, go to ERR.
  - Otherwise load the address counter.
- CNT_LO:
  - CNT=0 goes to CSUM, or to DONE when checksum is compiled out.
  - Otherwise go to DATA.
- DATA:
  - A byte counter runs 0..3. On the 4th byte, the word registers and `mem_we` pulses on the next cycle.
  - The address increments modulo 2^ADDR_W, so the write after 0x3FF goes to 0x000.
  - `words_loaded` increments with each write.
  - After word CNT, go to CSUM, or to DONE when checksum is compiled out.
- CSUM:
  - The expected value is the XOR of every byte after sync.
  - Match goes to DONE. Mismatch goes to ERR.
- DONE: `done=1`, `cpu_hold=0`.
- ERR:
  - `error=1`, `cpu_hold=1`.
  - Words already written are not rolled back.
  - `in_ready=0`, and the stream stalls until `rst`.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_hold=1`, `done=0`, `error=0`, `words_loaded=0`.
- Byte throughput: one byte per cycle. There is no back-pressure except in ERR.
- Write latency: if the 4th byte of a word is accepted at edge N, `mem_we`, `mem_addr` and `mem_wdata` are high/valid from edge N+1 to edge N+2.
- `done` and `cpu_hold` change at the edge after the final byte (CSUM, or the last data byte).
- Reset mid-frame, including DATA with a partial word: return to the reset values. The partial word is never written.
- Gaps in `in_valid` do not affect the packing order.

## Configuration
- `MIPS_LOADER_CSUM_EN` defined: CSUM state and XOR accumulator are present, and a mismatch leads to ERR.
- `MIPS_LOADER_CSUM_EN` undefined: CSUM state and accumulator are removed, and the frame ends on the last data byte, or on CNT_LO when CNT=0.

## Structure
- Package `mips_loader_pkg`:
  - state enum type.
  - `SYNC_BYTE = 8'hA5`.
  - header field offsets.
- Sub-module `loader_word_pack`:
  - 2-bit byte counter and 32-bit shift register.
  - Outputs a one-cycle `word_valid` pulse with the word.
  - Cleared by `rst` or frame start.
- The top level holds the FSM, address counter, word count, checksum and outputs.

## Test plan
- Clean load: `A5 00 10 00 02 11 22 33 44 55 66 77 88 9A` -> writes [0x010]=0x11223344 and [0x011]=0x55667788, `done=1`, `cpu_hold=0`, `words_loaded=2`.
- Bad checksum: same frame ending in `9B` -> both words written, `error=1`, `done=0`, `cpu_hold=1`, `in_ready=0`.
- Address wrap: header addr 0x03FF, count 2 -> writes to 0x3FF then 0x000.
- Address range check: addr 0x0400 -> ERR after ADDR_LO, `mem_we` never asserted.
- Noise and gaps: bytes `00 FF` before sync, plus random `in_valid` gaps inside DATA -> noise ignored, words identical to the clean load.
- Zero count and reset mid-frame:
  - `A5 00 00 00 00 00` -> `done=1` with no writes.
  - `rst` after 2 data bytes -> no write, all outputs at reset values.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg
// Shared types and constants for the MIPS program loader.
//   state_t         loader FSM state encoding
//   SYNC_BYTE       frame start marker
//   OFS_* / HDR_LEN byte offsets of the header fields within a frame
// Optional checksum support is selected with the MIPS_LOADER_CSUM_EN macro
// (see mips_prog_loader); the CSUM state is always encoded so the type is
// identical in both builds.
package mips_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_DATA    = 4'd5,
    ST_CSUM    = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Header layout: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO
  localparam int OFS_SYNC    = 0;
  localparam int OFS_ADDR_HI = 1;
  localparam int OFS_ADDR_LO = 2;
  localparam int OFS_CNT_HI  = 3;
  localparam int OFS_CNT_LO  = 4;
  localparam int HDR_LEN     = 5;

endpackage

// File: rtl/mips_prog_loader_if.sv
// mips_prog_loader_if
// Byte stream input and memory write port of the program loader.
//   in_valid/in_ready/in_data   byte stream handshake (source -> loader)
//   mem_we/mem_addr/mem_wdata   single-cycle word write (loader -> memory)
// Modports:
//   slave  : the loader (consumes bytes, drives memory writes)
//   master : the stream source / memory model side
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_word_pack.sv
// loader_word_pack
// Packs accepted bytes MSB-first into 32-bit words.
//   clk1        system clock
//   rst         synchronous active-high reset
//   clear       frame start; discards any partial word
//   byte_valid  a data byte is accepted this cycle
//   byte_data   the accepted byte
//   byte_idx    position (0..3) the next accepted byte will take in the word
//   word_valid  one-cycle pulse, registered on the edge that took byte 3
//   word_data   completed word, held until the next completed word
module loader_word_pack (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  idx_r;
  logic [23:0] shift_r;
  logic        word_valid_r;
  logic [31:0] word_r;

  // Byte counter, shift register and completed-word register
  always_ff @(posedge clk1) begin
    if (rst) begin
      idx_r        <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
      word_r       <= 32'd0;
    end else if (clear) begin
      idx_r        <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (byte_valid) begin
        shift_r <= {shift_r[15:0], byte_data};
        idx_r   <= idx_r + 2'd1;
        // Earlier bytes sit in the upper lanes: first byte lands in [31:24]
        if (idx_r == 2'd3) begin
          word_valid_r <= 1'b1;
          word_r       <= {shift_r, byte_data};
        end
      end
    end
  end

  assign byte_idx   = idx_r;
  assign word_valid = word_valid_r;
  assign word_data  = word_r;

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Loads a framed byte stream into the unified MIPS word memory and holds the
// CPU halted until a frame completes cleanly.
// Frame: A5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT*4 data bytes [, CSUM]
// Build option: define MIPS_LOADER_CSUM_EN to add the trailing XOR checksum
// byte (XOR of every byte after sync); a mismatch ends in the error state.
// Ports:
//   clk1          system clock (rising edge)
//   rst           synchronous active-high reset
//   bus           slave side of mips_prog_loader_if (byte stream + mem write)
//   cpu_hold      pipeline halt, low only after a clean frame
//   done          last frame loaded cleanly
//   error         frame error, sticky until rst (stream stalls)
//   words_loaded  words written by the current frame
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  mips_prog_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef MIPS_LOADER_CSUM_EN
  localparam state_t ST_END = ST_CSUM;
`else
  localparam state_t ST_END = ST_DONE;
`endif

  state_t            state_r, state_nxt;
  logic              accept_s;
  logic [15:0]       addr16_s;
  logic [15:0]       cnt16_s;
  logic              addr_bad_s;
  logic              frame_start_s;
  logic              pack_byte_s;
  logic [1:0]        pack_idx_s;
  logic              pack_valid_s;
  logic [31:0]       pack_word_s;

  logic [7:0]        addr_hi_r;
  logic [7:0]        cnt_hi_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       cnt_r;
  logic [15:0]       words_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              done_s, hold_s, err_s;
  logic              done_r, hold_r, err_r;
`ifdef MIPS_LOADER_CSUM_EN
  logic [7:0]        csum_r;
`endif

  // ERR is the only state that refuses bytes
  assign bus.in_ready = (state_r != ST_ERR);
  assign accept_s     = bus.in_valid && (state_r != ST_ERR);

  assign addr16_s   = {addr_hi_r, bus.in_data};
  assign cnt16_s    = {cnt_hi_r, bus.in_data};
  assign addr_bad_s = ((addr16_s >> ADDR_W) != 16'd0);

  assign frame_start_s = accept_s && ((state_r == ST_IDLE) || (state_r == ST_DONE))
                         && (bus.in_data == SYNC_BYTE);
  assign pack_byte_s   = accept_s && (state_r == ST_DATA);

  loader_word_pack u_pack (
    .clk1       (clk1),
    .rst        (rst),
    .clear      (frame_start_s),
    .byte_valid (pack_byte_s),
    .byte_data  (bus.in_data),
    .byte_idx   (pack_idx_s),
    .word_valid (pack_valid_s),
    .word_data  (pack_word_s)
  );

  // FSM state register
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.in_data == SYNC_BYTE) begin
            state_nxt = ST_ADDR_HI;
          end else begin
            state_nxt = state_r;
          end
        end
        ST_ADDR_HI: state_nxt = ST_ADDR_LO;
        ST_ADDR_LO: begin
          if (addr_bad_s) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_CNT_HI;
          end
        end
        ST_CNT_HI: state_nxt = ST_CNT_LO;
        ST_CNT_LO: begin
          if (cnt16_s == 16'd0) begin
            state_nxt = ST_END;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          // cnt_r counts words still to come, so 1 means this is the last one
          if ((pack_idx_s == 2'd3) && (cnt_r == 16'd1)) begin
            state_nxt = ST_END;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_CSUM: begin
`ifdef MIPS_LOADER_CSUM_EN
          if (bus.in_data == csum_r) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ERR;
          end
`else
          state_nxt = ST_ERR;
`endif
        end
        ST_ERR:  state_nxt = ST_ERR;
        default: state_nxt = ST_IDLE;
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // FSM output decode from the upcoming state, registered below
  always_comb begin
    done_s = 1'b0;
    hold_s = 1'b1;
    err_s  = 1'b0;
    case (state_nxt)
      ST_DONE: begin
        done_s = 1'b1;
        hold_s = 1'b0;
      end
      ST_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
        hold_s = 1'b1;
        err_s  = 1'b0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      done_r <= 1'b0;
      hold_r <= 1'b1;
      err_r  <= 1'b0;
    end else begin
      done_r <= done_s;
      hold_r <= hold_s;
      err_r  <= err_s;
    end
  end

  // Header capture, address/word counters and the memory write port
  always_ff @(posedge clk1) begin
    if (rst) begin
      addr_hi_r   <= 8'd0;
      cnt_hi_r    <= 8'd0;
      addr_r      <= '0;
      cnt_r       <= 16'd0;
      words_r     <= 16'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      // The write lands one cycle after the packer registers the word
      mem_we_r <= pack_valid_s;
      if (pack_valid_s) begin
        mem_wdata_r <= pack_word_s;
        mem_addr_r  <= addr_r;
        addr_r      <= addr_r + ADDR_W'(1);
        words_r     <= words_r + 16'd1;
      end
      if (accept_s) begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (bus.in_data == SYNC_BYTE) begin
              words_r <= 16'd0;
            end
          end
          ST_ADDR_HI: addr_hi_r <= bus.in_data;
          ST_ADDR_LO: addr_r    <= addr16_s[ADDR_W-1:0];
          ST_CNT_HI:  cnt_hi_r  <= bus.in_data;
          ST_CNT_LO:  cnt_r     <= cnt16_s;
          ST_DATA: begin
            if (pack_idx_s == 2'd3) begin
              cnt_r <= cnt_r - 16'd1;
            end
          end
          default: begin
            cnt_r <= cnt_r;
          end
        endcase
      end
    end
  end

`ifdef MIPS_LOADER_CSUM_EN
  // Running XOR of every byte after sync
  always_ff @(posedge clk1) begin
    if (rst) begin
      csum_r <= 8'd0;
    end else if (frame_start_s) begin
      csum_r <= 8'd0;
    end else if (accept_s && (state_r >= ST_ADDR_HI) && (state_r <= ST_DATA)) begin
      csum_r <= csum_r ^ bus.in_data;
    end
  end
`endif

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = hold_r;
  assign done          = done_r;
  assign error         = err_r;
  assign words_loaded  = words_r;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader
// Directed self-checking bench for mips_prog_loader. Works in both builds;
// with MIPS_LOADER_CSUM_EN defined each frame carries its checksum byte and
// the bad-checksum case is exercised.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        cpu_hold, done, error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] frame_words [0:3];
  logic [9:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  mips_prog_loader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mips_prog_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk1         (clk1),
    .rst          (rst),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk1 = ~clk1;

  // Record every memory write seen on the bus
  always @(posedge clk1) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Sends a full frame built from frame_words; checksum appended when enabled
  task automatic send_frame(input logic [15:0] addr, input logic [15:0] cnt,
                            input bit gaps, input bit bad_csum);
    logic [7:0]  hdr [0:HDR_LEN-1];
    logic [7:0]  x;
    logic [31:0] w;
    hdr[OFS_SYNC]    = SYNC_BYTE;
    hdr[OFS_ADDR_HI] = addr[15:8];
    hdr[OFS_ADDR_LO] = addr[7:0];
    hdr[OFS_CNT_HI]  = cnt[15:8];
    hdr[OFS_CNT_LO]  = cnt[7:0];
    x = 8'h00;
    for (int i = 0; i < HDR_LEN; i++) begin
      send_byte(hdr[i]);
      if (i != OFS_SYNC) x = x ^ hdr[i];
    end
    for (int k = 0; k < int'(cnt); k++) begin
      w = frame_words[k];
      for (int b = 3; b >= 0; b--) begin
        if (gaps) idle($urandom_range(0, 2));
        send_byte(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
`ifdef MIPS_LOADER_CSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x);
`endif
    idle(3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_mem_we"},   {31'd0, bus.mem_we},   32'd0);
    check({tag, "_mem_addr"}, {22'd0, bus.mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,        32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold},     32'd1);
    check({tag, "_done"},     {31'd0, done},         32'd0);
    check({tag, "_error"},    {31'd0, error},        32'd0);
    check({tag, "_words"},    {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic check_clean_two(input string tag);
    check({tag, "_nwr"},   wr_addr_q.size(), 32'd2);
    check({tag, "_a0"},    {22'd0, wr_addr_q[0]}, 32'h010);
    check({tag, "_d0"},    wr_data_q[0], 32'h11223344);
    check({tag, "_a1"},    {22'd0, wr_addr_q[1]}, 32'h011);
    check({tag, "_d1"},    wr_data_q[1], 32'h55667788);
    check({tag, "_done"},  {31'd0, done}, 32'd1);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    check({tag, "_err"},   {31'd0, error}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
    check_reset_values("rst");

    // Clean load: A5 00 10 00 02 11 22 33 44 55 66 77 88 [9A]
    clear_writes();
    frame_words[0] = 32'h11223344;
    frame_words[1] = 32'h55667788;
    send_frame(16'h0010, 16'd2, 1'b0, 1'b0);
    check_clean_two("clean");

    // Write latency: 4th byte at edge N -> mem_we high N+1..N+2 only
    clear_writes();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("lat_we_n", {31'd0, bus.mem_we}, 32'd0);
    idle(1);
    check("lat_we_n1", {31'd0, bus.mem_we}, 32'd1);
    check("lat_addr",  {22'd0, bus.mem_addr}, 32'h020);
    check("lat_data",  bus.mem_wdata, 32'hDEADBEEF);
    idle(1);
    check("lat_we_n2", {31'd0, bus.mem_we}, 32'd0);
`ifdef MIPS_LOADER_CSUM_EN
    send_byte(8'h03);
`endif
    idle(2);
    check("lat_done",  {31'd0, done}, 32'd1);
    check("lat_words", {16'd0, words_loaded}, 32'd1);

    // Address wrap: 0x3FF then 0x000
    clear_writes();
    frame_words[0] = 32'hCAFEF00D;
    frame_words[1] = 32'h0BADBEEF;
    send_frame(16'h03FF, 16'd2, 1'b0, 1'b0);
    check("wrap_nwr", wr_addr_q.size(), 32'd2);
    check("wrap_a0",  {22'd0, wr_addr_q[0]}, 32'h3FF);
    check("wrap_d0",  wr_data_q[0], 32'hCAFEF00D);
    check("wrap_a1",  {22'd0, wr_addr_q[1]}, 32'h000);
    check("wrap_d1",  wr_data_q[1], 32'h0BADBEEF);
    check("wrap_done", {31'd0, done}, 32'd1);

    // Noise before sync and gaps inside DATA
    clear_writes();
    frame_words[0] = 32'h11223344;
    frame_words[1] = 32'h55667788;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(16'h0010, 16'd2, 1'b1, 1'b0);
    check_clean_two("noise");

    // Zero count: done with no writes
    clear_writes();
    send_frame(16'h0000, 16'd0, 1'b0, 1'b0);
    check("zero_nwr",   wr_addr_q.size(), 32'd0);
    check("zero_done",  {31'd0, done}, 32'd1);
    check("zero_hold",  {31'd0, cpu_hold}, 32'd0);
    check("zero_words", {16'd0, words_loaded}, 32'd0);

    // Reset after two data bytes: partial word is dropped
    clear_writes();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    check_reset_values("midrst");
    idle(4);
    check("midrst_nwr", wr_addr_q.size(), 32'd0);

    // Address out of range: ERR after ADDR_LO, never writes, stalls
    clear_writes();
    frame_words[0] = 32'h01020304;
    send_frame(16'h0400, 16'd1, 1'b0, 1'b0);
    check("range_nwr",   wr_addr_q.size(), 32'd0);
    check("range_err",   {31'd0, error}, 32'd1);
    check("range_ready", {31'd0, bus.in_ready}, 32'd0);
    check("range_hold",  {31'd0, cpu_hold}, 32'd1);
    check("range_done",  {31'd0, done}, 32'd0);
    send_byte(8'hA5);
    idle(2);
    check("range_sticky", {31'd0, error}, 32'd1);
    do_reset();
    check("range_clr", {31'd0, error}, 32'd0);

`ifdef MIPS_LOADER_CSUM_EN
    // Bad checksum: words stay written, frame ends in ERR
    clear_writes();
    frame_words[0] = 32'h11223344;
    frame_words[1] = 32'h55667788;
    send_frame(16'h0010, 16'd2, 1'b0, 1'b1);
    check("bad_nwr",   wr_addr_q.size(), 32'd2);
    check("bad_d1",    wr_data_q[1], 32'h55667788);
    check("bad_err",   {31'd0, error}, 32'd1);
    check("bad_done",  {31'd0, done}, 32'd0);
    check("bad_hold",  {31'd0, cpu_hold}, 32'd1);
    check("bad_ready", {31'd0, bus.in_ready}, 32'd0);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
